pixel_writer4bit: RTL and testbench
===================================

# pixel_writer4bit

Write-side companion to the 4-bit pixel reader. It accepts a pixel coordinate (x, y, z) and a 4-bit value from the CPU on a trigger rising edge. It then performs a read-modify-write on the packed pixel memory, replacing only the addressed nibble, and reports completion or a range error back to the CPU. It sits between the CPU register interface and the single-port pixel SRAM, sharing the reader's memory handshake.

## Interface

- IMG_W, 28: image width in pixels
- IMG_H, 28: image height in pixels
- IMG_C, 3: channel count
- DATA_WIDTH, 32: memory word width; must be a multiple of 4; pixels per word PPW = DATA_WIDTH/4
- ADDR_WIDTH, 16: memory address width
- BASE_ADDR, 0: word address of pixel index 0

- clock  input  1  clock, rising-edge
- rst  input  1  reset rst, asynchronous, active-high
- x  input  32 (int)  pixel column, from CPU
- y  input  32 (int)  pixel row, from CPU
- z  input  32 (int)  channel, from CPU
- p  input  4  pixel value to write, from CPU
- trigger  input  1  start request from CPU; a 0→1 edge starts a write
- data_ready_mem  input  1  memory acknowledge for the current read or write
- mem_rdata  input  DATA_WIDTH  read data; valid while data_ready_mem=1 during a read
- csb  output  1  memory chip select, active-low
- we  output  1  memory write enable; 1=write, 0=read
- addr  output  ADDR_WIDTH  memory word address
- mem_wdata  output  DATA_WIDTH  write data
- busy  output  1  high from the cycle after an accepted edge until the cycle before done
- done  output  1  one-cycle completion pulse
- err  output  1  last request was out of range; held until the next accepted edge

## Operation

- Edge detect: `trigger_prev` is a register, reset to 0. An edge is `trigger && !trigger_prev`. `trigger_prev` follows trigger every cycle, in every state.
- States: IDLE, CALC, RD, WR, DONE.
- IDLE: on an edge, latch x, y, z and p, clear err, and go to CALC. Edges seen in any other state are ignored and are not queued; the CPU must drop trigger and raise it again.
- CALC: check the range 0≤x<IMG_W, 0≤y<IMG_H, 0≤z<IMG_C, using signed comparisons.
  - If out of range: set err=1 and go to DONE. No memory access is made.
  - If in range: compute idx = (z*IMG_H + y)*IMG_W + x in 32-bit unsigned arithmetic, then word = idx / PPW and nib = idx % PPW. Register addr = BASE_ADDR + word, truncated to ADDR_WIDTH. Go to RD.
- RD: drive csb=0 and we=0, holding addr. On data_ready_mem=1, register mem_wdata = mem_rdata with bits [4*nib+3 : 4*nib] replaced by p, then go to WR.
- WR: drive csb=0 and we=1, holding addr and mem_wdata. On data_ready_mem=1, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Pixel k of a word occupies bits [4k+3:4k]. Nibble 0 is the LSBs.
- All outputs are registered.

## Timing

- Reset values: csb=1, we=0, addr=0, mem_wdata=0, busy=0, done=0, err=0, state=IDLE, trigger_prev=0.
- The edge is sampled at rising edge T, which moves the FSM to CALC. Busy is high during cycles T+1 through the last WR cycle.
- With a zero-wait memory (data_ready_mem=1 in the first request cycle):
  - CALC at T+1
  - RD at T+2
  - WR at T+3
  - done=1 at T+4
- Each memory wait cycle adds one cycle. csb, we and addr stay stable until the acknowledge.
- csb returns to 1 in the cycle after the WR acknowledge. There is no idle cycle between RD and WR; csb stays 0 and only we changes.
- Out-of-range request: done=1 at T+2 and err=1 from T+2. csb never goes low.
- data_ready_mem is ignored in IDLE, CALC and DONE.
- Reset mid-operation: outputs return to their reset values immediately (asynchronous). An interrupted RD or WR is abandoned and no done pulse is issued.
- If trigger is held high through reset release, the first clock counts as an edge, because trigger_prev resets to 0.

## Test plan

- Basic write, W=28, zero-wait memory: x=3, y=1, z=0, p=4'hA gives idx=31, addr=3, nib 7. mem_rdata=32'h1234_5678 → WR with mem_wdata=32'hA234_5678, done at T+4, err=0.
- Channel offset: x=0, y=0, z=1, p=0, mem_rdata=32'hFFFF_FFFF → addr=98, mem_wdata=32'hFFFF_FFF0.
- Out of range: x=28, then in a separate request z=-1 → err=1 and done at T+2, with csb=1 throughout. A following valid request clears err.
- Wait states: data_ready_mem delayed 3 cycles in both RD and WR → addr, we and mem_wdata stay stable throughout, and done arrives at T+10.
- Busy re-trigger: trigger toggles 0→1→0→1 during RD → only one RMW and one done pulse. A new edge after done is accepted.
- Reset in WR: assert rst while csb=0 → csb=1, busy=0 and done=0 immediately. After release, trigger low then high → a fresh RMW completes normally.

Source files
------------

// File: rtl/pixel_writer4bit.sv
// Nibble read-modify-write of packed 4-bit pixel memory, started by a CPU trigger edge.
// Latency: done 4 cycles after the edge with a zero-wait memory; each memory wait adds one.
module pixel_writer4bit #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int IMG_C      = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic signed [31:0]    x,
  input  logic signed [31:0]    y,
  input  logic signed [31:0]    z,
  input  logic [3:0]            p,
  input  logic                  trigger,
  input  logic                  data_ready_mem,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  csb,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int PPW   = DATA_WIDTH / 4;
  localparam int NIB_W = (PPW > 1) ? $clog2(PPW) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]          r_state;
  logic                r_trigger_prev;
  logic signed [31:0]  r_x;
  logic signed [31:0]  r_y;
  logic signed [31:0]  r_z;
  logic [3:0]          r_p;
  logic [NIB_W-1:0]    r_nib;

  logic                w_edge;
  logic                w_in_range;
  logic [31:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_pix;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_edge     = trigger && !r_trigger_prev;
  assign w_in_range = (r_x >= 0) && (r_x < IMG_W) &&
                      (r_y >= 0) && (r_y < IMG_H) &&
                      (r_z >= 0) && (r_z < IMG_C);

  // Only consumed when in range, so the unsigned view of the coordinates is exact.
  assign w_idx = ($unsigned(r_z) * 32'(IMG_H) + $unsigned(r_y)) * 32'(IMG_W) + $unsigned(r_x);

  assign w_mask   = DATA_WIDTH'(4'hF) << {r_nib, 2'b00};
  assign w_pix    = DATA_WIDTH'(r_p) << {r_nib, 2'b00};
  assign w_merged = (mem_rdata & ~w_mask) | w_pix;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_trigger_prev <= 1'b0;
      r_x            <= '0;
      r_y            <= '0;
      r_z            <= '0;
      r_p            <= '0;
      r_nib          <= '0;
      csb            <= 1'b1;
      we             <= 1'b0;
      addr           <= '0;
      mem_wdata      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      r_trigger_prev <= trigger;
      done           <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_x     <= x;
            r_y     <= y;
            r_z     <= z;
            r_p     <= p;
            err     <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (!w_in_range) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            addr    <= ADDR_WIDTH'(32'(BASE_ADDR) + w_idx / 32'(PPW));
            r_nib   <= NIB_W'(w_idx % 32'(PPW));
            csb     <= 1'b0;
            we      <= 1'b0;
            r_state <= S_RD;
          end
        end
        S_RD: begin
          if (data_ready_mem) begin
            mem_wdata <= w_merged;
            we        <= 1'b1;
            r_state   <= S_WR;
          end
        end
        S_WR: begin
          if (data_ready_mem) begin
            csb     <= 1'b1;
            we      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_writer4bit.sv
// Bench for pixel_writer4bit: directed vector table, corner sequences and random
// requests checked against an arithmetic reference model with a reactive memory.
module tb_pixel_writer4bit;

  localparam int IMG_W      = 28;
  localparam int IMG_H      = 28;
  localparam int IMG_C      = 3;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 16;
  localparam int BASE_ADDR  = 0;
  localparam int PPW        = DATA_WIDTH / 4;

  logic                  clock;
  logic                  rst;
  logic signed [31:0]    x, y, z;
  logic [3:0]            p;
  logic                  trigger;
  logic                  data_ready_mem;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  csb, we, busy, done, err;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          vx, vy, vz;
    logic [3:0]  vp;
    logic [31:0] rdata;
    int          rdw, wrw;
    logic        e_err;
    logic [15:0] e_addr;
    logic [31:0] e_wdata;
    int          e_done;
  } vec_t;

  vec_t vecs [11];

  pixel_writer4bit #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .IMG_C(IMG_C),
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clock(clock), .rst(rst), .x(x), .y(y), .z(z), .p(p), .trigger(trigger),
    .data_ready_mem(data_ready_mem), .mem_rdata(mem_rdata),
    .csb(csb), .we(we), .addr(addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: range rule, linear pixel index, word/nibble split, nibble replacement.
  task automatic model(input int tx, ty, tz, input logic [3:0] tp, input logic [31:0] rd,
                       input int rdw, wrw, output logic e_err, output logic [15:0] e_addr,
                       output logic [31:0] e_wdata, output int e_done);
    logic [3:0] nibs [PPW];
    int idx;
    e_err   = !(tx >= 0 && tx < IMG_W && ty >= 0 && ty < IMG_H && tz >= 0 && tz < IMG_C);
    e_addr  = '0;
    e_wdata = '0;
    if (!e_err) begin
      idx    = (tz * IMG_H + ty) * IMG_W + tx;
      e_addr = 16'(BASE_ADDR + idx / PPW);
      for (int k = 0; k < PPW; k++) nibs[k] = rd[4*k +: 4];
      nibs[idx % PPW] = tp;
      for (int k = 0; k < PPW; k++) e_wdata[4*k +: 4] = nibs[k];
    end
    e_done = e_err ? 2 : 4 + rdw + wrw;
  endtask

  // Entered just after the edge-sampling clock; acts as the memory and checks the transaction.
  task automatic run_txn(input string tag, input int rdw, wrw, input logic [31:0] rdata,
                         input logic e_err, input logic [15:0] e_addr,
                         input logic [31:0] e_wdata, input int e_done);
    int rd_cnt, wr_cnt, done_cyc, busy_bad, unstable, csb_done_bad;
    logic [15:0] a0;
    logic [31:0] wd0;
    logic        err_at_done;
    rd_cnt = 0; wr_cnt = 0; done_cyc = -1; busy_bad = 0; unstable = 0; csb_done_bad = 0;
    a0 = '0; wd0 = '0; err_at_done = 1'b0;
    trigger = 1'b0;
    check({tag, " err_clr"}, err, 0);
    for (int c = 1; c <= 40; c++) begin
      if (busy !== (c < e_done)) busy_bad++;
      if (done) begin
        done_cyc    = c;
        err_at_done = err;
        if (!csb) csb_done_bad++;
        data_ready_mem = 1'b0;
        break;
      end
      data_ready_mem = 1'b0;
      mem_rdata      = $urandom();
      if (!csb) begin
        if (rd_cnt == 0 && wr_cnt == 0) a0 = addr;
        else if (addr !== a0) unstable++;
        if (!we) begin
          rd_cnt++;
          if (rd_cnt == rdw + 1) begin
            data_ready_mem = 1'b1;
            mem_rdata      = rdata;
          end
        end else begin
          wr_cnt++;
          if (wr_cnt == 1) wd0 = mem_wdata;
          else if (mem_wdata !== wd0) unstable++;
          if (wr_cnt == wrw + 1) data_ready_mem = 1'b1;
        end
      end else begin
        data_ready_mem = 1'($urandom_range(0, 1));
      end
      step();
    end
    data_ready_mem = 1'b0;
    check({tag, " done_cycle"}, done_cyc, e_done);
    check({tag, " err"}, err_at_done, e_err);
    check({tag, " busy"}, busy_bad, 0);
    check({tag, " csb_at_done"}, csb_done_bad, 0);
    if (e_err) begin
      check({tag, " no_mem_access"}, rd_cnt + wr_cnt, 0);
    end else begin
      check({tag, " addr"}, a0, e_addr);
      check({tag, " wdata"}, wd0, e_wdata);
      check({tag, " rd_cycles"}, rd_cnt, rdw + 1);
      check({tag, " wr_cycles"}, wr_cnt, wrw + 1);
      check({tag, " stable"}, unstable, 0);
    end
    step();
    check({tag, " done_single"}, done, 0);
    check({tag, " err_hold"}, err, e_err);
    check({tag, " csb_idle"}, csb, 1);
  endtask

  task automatic do_txn(input string tag, input int tx, ty, tz, input logic [3:0] tp,
                        input logic [31:0] rdata, input int rdw, wrw, input logic e_err,
                        input logic [15:0] e_addr, input logic [31:0] e_wdata, input int e_done);
    trigger = 1'b0;
    step();
    x = tx; y = ty; z = tz; p = tp;
    trigger = 1'b1;
    step();
    run_txn(tag, rdw, wrw, rdata, e_err, e_addr, e_wdata, e_done);
  endtask

  logic        m_err;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;
  int          m_done;
  int          r_x, r_y, r_z, r_rdw, r_wrw;
  logic [3:0]  r_p;
  logic [31:0] r_rd;
  int          dn, rd_entries, rdc, wait_n;
  logic        prev_csb;
  logic [31:0] rt_wd;

  initial begin
    vecs[0]  = '{3,  1,  0,  4'hA, 32'h1234_5678, 0, 0, 1'b0, 16'd3,   32'hA234_5678, 4};
    vecs[1]  = '{0,  0,  1,  4'h0, 32'hFFFF_FFFF, 0, 0, 1'b0, 16'd98,  32'hFFFF_FFF0, 4};
    vecs[2]  = '{28, 0,  0,  4'h7, 32'h0,         0, 0, 1'b1, 16'd0,   32'h0,         2};
    vecs[3]  = '{0,  0,  -1, 4'h7, 32'h0,         0, 0, 1'b1, 16'd0,   32'h0,         2};
    vecs[4]  = '{5,  2,  2,  4'h5, 32'h0,         3, 3, 1'b0, 16'd203, 32'h0050_0000, 10};
    vecs[5]  = '{27, 27, 2,  4'hF, 32'h0,         0, 0, 1'b0, 16'd293, 32'hF000_0000, 4};
    vecs[6]  = '{0,  28, 0,  4'h1, 32'h0,         0, 0, 1'b1, 16'd0,   32'h0,         2};
    vecs[7]  = '{0,  0,  3,  4'h1, 32'h0,         0, 0, 1'b1, 16'd0,   32'h0,         2};
    vecs[8]  = '{-1, 0,  0,  4'h1, 32'h0,         0, 0, 1'b1, 16'd0,   32'h0,         2};
    vecs[9]  = '{1,  0,  0,  4'h3, 32'hFFFF_FFFF, 1, 0, 1'b0, 16'd0,   32'hFFFF_FF3F, 5};
    vecs[10] = '{2,  0,  0,  4'hC, 32'h7654_3210, 0, 2, 1'b0, 16'd0,   32'h7654_3C10, 6};

    rst = 1'b1; trigger = 1'b0; data_ready_mem = 1'b0; mem_rdata = '0;
    x = 0; y = 0; z = 0; p = 4'h0;
    step(); step();
    check("reset csb", csb, 1);
    check("reset we", we, 0);
    check("reset addr", addr, 0);
    check("reset wdata", mem_wdata, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 11; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].vx, vecs[i].vy, vecs[i].vz, vecs[i].vp,
             vecs[i].rdata, vecs[i].rdw, vecs[i].wrw, vecs[i].e_err, vecs[i].e_addr,
             vecs[i].e_wdata, vecs[i].e_done);
    end

    // Trigger toggling during RD must not start a second operation.
    trigger = 1'b0; step();
    x = 0; y = 0; z = 1; p = 4'h5;
    trigger = 1'b1; step();
    trigger = 1'b0;
    dn = 0; rd_entries = 0; rdc = 0; prev_csb = 1'b1; rt_wd = '0;
    for (int c = 0; c < 30; c++) begin
      if (done) dn++;
      if (prev_csb && !csb) rd_entries++;
      prev_csb = csb;
      data_ready_mem = 1'b0;
      if (!csb && !we) begin
        rdc++;
        if (rdc < 4) trigger = rdc[0];
        else begin
          data_ready_mem = 1'b1;
          mem_rdata      = 32'hFFFF_FFFF;
        end
      end else if (!csb && we) begin
        rt_wd          = mem_wdata;
        data_ready_mem = 1'b1;
      end
      step();
    end
    data_ready_mem = 1'b0;
    check("retrig done_pulses", dn, 1);
    check("retrig accesses", rd_entries, 1);
    check("retrig wdata", rt_wd, 32'hFFFF_FFF5);
    do_txn("after_retrig", 0, 0, 1, 4'h0, 32'hFFFF_FFFF, 0, 0, 1'b0, 16'd98, 32'hFFFF_FFF0, 4);

    // Reset while the write is outstanding.
    trigger = 1'b0; step();
    x = 3; y = 1; z = 0; p = 4'h6;
    trigger = 1'b1; step();
    trigger = 1'b0;
    wait_n = 0;
    while (!(!csb && !we) && wait_n < 10) begin
      step();
      wait_n++;
    end
    data_ready_mem = 1'b1; mem_rdata = 32'h0;
    step();
    data_ready_mem = 1'b0;
    check("rstwr reach_wr", {csb, we}, 2'b01);
    rst = 1'b1;
    #1;
    check("rstwr csb", csb, 1);
    check("rstwr we", we, 0);
    check("rstwr busy", busy, 0);
    check("rstwr done", done, 0);
    step(); step();
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (done) dn++;
    end
    check("rstwr no_done", dn, 0);
    do_txn("after_rst", 3, 1, 0, 4'hA, 32'h1234_5678, 0, 0, 1'b0, 16'd3, 32'hA234_5678, 4);

    // Trigger held high across reset release counts as an edge.
    rst = 1'b1; trigger = 1'b1;
    x = 5; y = 2; z = 2; p = 4'h5;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_edge busy", busy, 1);
    run_txn("rst_edge", 0, 1, 32'h0, 1'b0, 16'd203, 32'h0050_0000, 5);

    for (int i = 0; i < 40; i++) begin
      r_x   = int'($urandom_range(0, 29)) - 1;
      r_y   = int'($urandom_range(0, 29)) - 1;
      r_z   = int'($urandom_range(0, 4)) - 1;
      r_p   = 4'($urandom());
      r_rd  = $urandom();
      r_rdw = int'($urandom_range(0, 3));
      r_wrw = int'($urandom_range(0, 3));
      model(r_x, r_y, r_z, r_p, r_rd, r_rdw, r_wrw, m_err, m_addr, m_wdata, m_done);
      do_txn($sformatf("rand%0d", i), r_x, r_y, r_z, r_p, r_rd, r_rdw, r_wrw,
             m_err, m_addr, m_wdata, m_done);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
